// File: rtl/afifo_rd_stream_ctrl_if.sv
// Bundles the control, FIFO-read and output-stream signals of the read-stream controller.
// The master modport is the controller's view; the slave modport is the environment's
// view: the command source, the FIFO read port and the stream consumer.
interface afifo_rd_stream_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  start;
    logic [CNT_WIDTH-1:0]  cfg_len;
    logic                  busy;
    logic                  done;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_empty;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic [CNT_WIDTH-1:0]  words_out;

    modport master (
        input  start, cfg_len, fifo_rd_data, fifo_rd_empty, m_ready,
        output busy, done, fifo_rd_en, m_valid, m_data, m_last, words_out
    );

    modport slave (
        output start, cfg_len, fifo_rd_data, fifo_rd_empty, m_ready,
        input  busy, done, fifo_rd_en, m_valid, m_data, m_last, words_out
    );
endinterface

// File: rtl/afifo_rd_stream_ctrl.sv
// Read-side frame controller for the async FIFO. It drains cfg_len words per start command
// and presents them as a valid/ready stream. The FIFO's one-cycle read latency is absorbed
// by a 2-entry skid buffer. A read is only issued when the buffer is guaranteed to have
// room for the returning word, so backpressure never drops or repeats data.
module afifo_rd_stream_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    afifo_rd_stream_ctrl_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  issued_q;
    logic [CNT_WIDTH-1:0]  words_out_q;
    logic                  busy_q;
    logic                  done_q;

    // Skid buffer: two slots, head pointer and occupancy; infl_q marks a read in flight.
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  head_q;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  infl_q;

    logic                  pop;
    logic                  push;
    logic                  tail;
    logic                  room;
    logic                  rd_en;
    logic                  start_ok;
    logic                  last_hs;
    logic [CNT_WIDTH-1:0]  len_m1;
    logic [CNT_WIDTH-1:0]  issued_inc;

    // Handshake, read-issue and capacity decisions for the current cycle.
    always_comb begin
        pop        = (occ_q != 2'd0) & bus.m_ready;
        push       = infl_q;
        // For occupancy 0, 1 and 2 (2 only with a pop) the free slot is head ^ occ[0].
        tail       = head_q ^ occ_q[0];
        occ_d      = occ_q + 2'(push) - 2'(pop);
        // Count the word already in flight so a newly issued read always has a slot.
        room       = (({1'b0, occ_q} + 3'(infl_q) - 3'(pop)) < 3'd2);
        issued_inc = issued_q + CNT_WIDTH'(1);
        len_m1     = len_q - CNT_WIDTH'(1);
        rd_en      = (state_q == StRun) & ~bus.fifo_rd_empty & (issued_q < len_q) & room;
        start_ok   = (state_q == StIdle) & bus.start & (bus.cfg_len != '0);
        last_hs    = pop & (words_out_q == len_m1);
    end

    // Skid buffer storage: returning read data is written at the tail, the head is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            occ_q    <= 2'd0;
            infl_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[tail] <= bus.fifo_rd_data;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            occ_q  <= occ_d;
            infl_q <= rd_en;
        end
    end

    // Frame FSM with counters and registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            issued_q    <= '0;
            words_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop && (words_out_q != len_q)) begin
                words_out_q <= words_out_q + CNT_WIDTH'(1);
            end
            if (rd_en) begin
                issued_q <= issued_inc;
            end
            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        len_q       <= bus.cfg_len;
                        issued_q    <= '0;
                        words_out_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= StRun;
                    end
                end
                StRun: begin
                    if (rd_en && (issued_inc == len_q)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (last_hs) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output drive: stream from the skid head, status from registers.
    always_comb begin
        bus.fifo_rd_en = rd_en;
        bus.m_valid    = (occ_q != 2'd0);
        bus.m_data     = mem_q[head_q];
        bus.m_last     = (occ_q != 2'd0) & (words_out_q == len_m1);
        bus.busy       = busy_q;
        bus.done       = done_q;
        bus.words_out  = words_out_q;
    end

endmodule

// File: tb/tb_afifo_rd_stream_ctrl.sv
// Scoreboard bench for afifo_rd_stream_ctrl: a FIFO model serves reads, stimulus pushes
// expected words per frame, and a negedge monitor compares every stream handshake.
module tb_afifo_rd_stream_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    afifo_rd_stream_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    afifo_rd_stream_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] fifo_q [$];
    exp_t          exp_q [$];
    int            exp_len = 0;
    int            occ_cnt = 0;
    int            rd_total = 0;
    int            hs_frame = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    bit            prev_last_hs = 0;
    bit            pend_valid = 0;
    logic [DW-1:0] pend_data = '0;
    logic          hs_w;
    exp_t          e_w;
    bit            rdy_mode = 0;
    int            pat_idx = 0;
    logic [15:0]   rdy_pat = 16'b1001_0110_1100_1011;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Monitor: FIFO read service, handshake scoreboard, hold and capacity checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            occ_cnt      = 0;
            prev_stall   = 0;
            prev_last_hs = 0;
            pend_valid   = 0;
        end else begin
            hs_w = bus.m_valid & bus.m_ready;
            if (prev_stall) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_data", bus.m_data, prev_data);
            end
            if (bus.fifo_rd_en) begin
                check("rd_en_while_empty", bus.fifo_rd_empty, 0);
                check("rd_en_capacity", ((occ_cnt - int'(hs_w)) < 2), 1);
                if (fifo_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL fifo_underflow: got read, expected none");
                    pend_data = '0;
                end else begin
                    pend_data = fifo_q.pop_front();
                end
                rd_total++;
            end
            pend_valid = bus.fifo_rd_en;
            if (hs_w) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, expected none", bus.m_data);
                end else begin
                    e_w = exp_q.pop_front();
                    check("m_data", bus.m_data, e_w.data);
                    check("m_last", bus.m_last, e_w.last);
                end
                hs_frame++;
            end
            if (bus.done) begin
                check("done_after_last", prev_last_hs, 1);
                check("done_words_out", bus.words_out, exp_len);
                check("done_busy", bus.busy, 1);
            end
            occ_cnt      = occ_cnt + int'(bus.fifo_rd_en) - int'(hs_w);
            prev_stall   = bus.m_valid & ~bus.m_ready;
            prev_data    = bus.m_data;
            prev_last_hs = hs_w & bus.m_last;
        end
    end

    // FIFO read port model: data valid the cycle after rd_en, empty registered.
    always @(posedge clk) begin
        if (pend_valid) bus.fifo_rd_data <= pend_data;
        bus.fifo_rd_empty <= (fifo_q.size() == 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_mode) begin
            bus.m_ready = rdy_pat[pat_idx];
            pat_idx = (pat_idx + 1) % 16;
        end
    endtask

    task automatic start_frame(input int len);
        bus.start   = 1'b1;
        bus.cfg_len = CW'(len);
        step();
        bus.start   = 1'b0;
    endtask

    task automatic load_fifo(input logic [DW-1:0] base, input int n, input int stp);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i * stp));
    endtask

    task automatic push_exp(input logic [DW-1:0] base, input int n, input int stp);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = base + DW'(i * stp);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        exp_len = n;
    endtask

    task automatic wait_done(input int budget, input string name, output int steps);
        bit seen;
        seen  = 0;
        steps = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            steps++;
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        check(name, seen, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_rd_en"}, bus.fifo_rd_en, 0);
        check({tag, "_m_valid"}, bus.m_valid, 0);
        check({tag, "_m_last"}, bus.m_last, 0);
        check({tag, "_words_out"}, bus.words_out, 0);
        check({tag, "_m_data"}, bus.m_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd0;
        int steps;
        bus.start   = 1'b0;
        bus.cfg_len = '0;
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        step();

        // 1: eight words, full throughput, latency and done timing.
        load_fifo(32'hFFFF_FFFF, 8, -1);
        step();
        push_exp(32'hFFFF_FFFF, 8, -1);
        rd0 = rd_total;
        start_frame(8);
        check("t1_busy", bus.busy, 1);
        step();
        check("t1_valid_c2", bus.m_valid, 0);
        step();
        check("t1_valid_c3", bus.m_valid, 1);
        wait_done(100, "t1_done", steps);
        check("t1_done_cycles", steps, 8);
        check("t1_rd_count", rd_total - rd0, 8);
        step();
        check("t1_busy_after", bus.busy, 0);
        check("t1_words_out", bus.words_out, 8);

        // 2: sixteen words under a toggling m_ready.
        load_fifo(32'h2000_0000, 16, 1);
        step();
        push_exp(32'h2000_0000, 16, 1);
        rdy_mode = 1;
        start_frame(16);
        wait_done(300, "t2_done", steps);
        rdy_mode = 0;
        bus.m_ready = 1'b1;
        step();
        check("t2_words_out", bus.words_out, 16);

        // 3: FIFO runs dry mid-frame, refilled 20 cycles later.
        load_fifo(32'h3000_0000, 3, 1);
        step();
        push_exp(32'h3000_0000, 6, 1);
        rd0 = rd_total;
        start_frame(6);
        repeat (20) step();
        check("t3_busy_gap", bus.busy, 1);
        check("t3_rd_gap", rd_total - rd0, 3);
        load_fifo(32'h3000_0003, 3, 1);
        wait_done(100, "t3_done", steps);
        check("t3_rd_count", rd_total - rd0, 6);
        step();
        check("t3_words_out", bus.words_out, 6);

        // 4: single-word frame, then a zero-length start.
        load_fifo(32'h4000_0001, 1, 1);
        step();
        push_exp(32'h4000_0001, 1, 1);
        start_frame(1);
        wait_done(100, "t4_done", steps);
        step();
        check("t4_words_out", bus.words_out, 1);
        load_fifo(32'h5000_0000, 5, 1);
        step();
        rd0 = rd_total;
        start_frame(0);
        check("t4_len0_busy", bus.busy, 0);
        repeat (4) step();
        check("t4_len0_busy_late", bus.busy, 0);
        check("t4_len0_rd", rd_total - rd0, 0);

        // 5: second start during RUN is ignored.
        push_exp(32'h5000_0000, 5, 1);
        rd0 = rd_total;
        start_frame(5);
        start_frame(99);
        wait_done(100, "t5_done", steps);
        check("t5_rd_count", rd_total - rd0, 5);
        step();
        check("t5_words_out", bus.words_out, 5);
        repeat (3) step();
        check("t5_busy_idle", bus.busy, 0);

        // 6: reset after five handshakes, then a fresh frame from what remains.
        load_fifo(32'h6000_0000, 20, 1);
        step();
        push_exp(32'h6000_0000, 20, 1);
        hs_frame = 0;
        start_frame(20);
        for (int i = 0; i < 100 && hs_frame < 5; i++) step();
        check("t6_hs_reached", hs_frame, 5);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        exp_q.delete();
        check("t6_fifo_left", fifo_q.size(), 13);
        step();
        check_zero("t6_idle");
        push_exp(32'h6000_0007, 4, 1);
        rd0 = rd_total;
        start_frame(4);
        wait_done(100, "t6_done", steps);
        check("t6_rd_count", rd_total - rd0, 4);
        step();
        check("t6_words_out", bus.words_out, 4);
        check("t6_fifo_after", fifo_q.size(), 9);

        check("exp_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
